// File: rtl/demux_burst_scheduler_pkg.sv
// Purpose : shared types and default constants for the DEMUX burst scheduler.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: state_t (IDLE/BURST/GAP), STATE_W, default parameter values.
package demux_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_SEL_W      = 3;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_GAP_CYCLES = 1;

endpackage

// File: rtl/demux_burst_scheduler_if.sv
// Purpose : bundles the request, upstream handshake and DEMUX control signals of the scheduler.
// Latency : n/a (wires only).
// Backpressure : Data_Ready_Out is the upstream ready; a beat moves on Data_Valid_In & Data_Ready_Out.
// Modports: master = upstream/consumer side (drives Req_In, Data_Valid_In, Data_In);
//           slave  = scheduler (drives ready, data, select, enable, grant and status pulses).
interface demux_burst_scheduler_if
    import demux_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
);
    logic [NUM_CH-1:0] Req_In;
    logic              Data_Valid_In;
    logic              Data_In;
    logic              Data_Ready_Out;
    logic              Data_Out;
    logic [SEL_W-1:0]  Select_Out;
    logic              Enable_Out;
    logic [NUM_CH-1:0] Grant_Out;
    logic              Busy_Out;
    logic              Burst_Done_Out;
    logic              Abort_Out;

    modport master (
        output Req_In, Data_Valid_In, Data_In,
        input  Data_Ready_Out, Data_Out, Select_Out, Enable_Out, Grant_Out,
               Busy_Out, Burst_Done_Out, Abort_Out
    );

    modport slave (
        input  Req_In, Data_Valid_In, Data_In,
        output Data_Ready_Out, Data_Out, Select_Out, Enable_Out, Grant_Out,
               Busy_Out, Burst_Done_Out, Abort_Out
    );

endinterface

// File: rtl/demux_burst_scheduler_rr_arbiter.sv
// Purpose : combinational round-robin picker; first set request after ptr, wrapping mod NUM_CH.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; vld low when no request is set.
// Ports: req (per-channel requests), ptr (last winner) -> gnt (one-hot), idx (binary), vld.
module rr_arbiter
    import demux_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  idx,
    output logic              vld
);

    logic [SEL_W-1:0] cand;

    // Scan ptr+1 .. ptr+NUM_CH so the previous winner is looked at last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = SEL_W'((int'(ptr) + i) % NUM_CH);
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/demux_burst_scheduler.sv
// Purpose : round-robin scheduler sharing one serial stream across NUM_CH DEMUX consumers in fixed bursts.
// Latency : grant 1 cycle after a request is seen in IDLE; Data_Out is a combinational pass of Data_In.
// Backpressure : Data_Ready_Out = Req_In[Select_Out] in BURST only; Valid low stalls the burst indefinitely.
// Ports: Clock_In, Reset_In (sync, active-high), bus (slave modport: requests, handshake, DEMUX control, status).
// Option: DEMUX_SCHED_PRIO_EN makes ch0 win every arbitration without moving the round-robin pointer.
module demux_burst_scheduler
    import demux_sched_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SEL_W      = DEF_SEL_W,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                    Clock_In,
    input  logic                    Reset_In,
    demux_burst_scheduler_if.slave  bus
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t AFTER_BURST = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              en_q, en_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;

    logic [NUM_CH-1:0] arb_gnt;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_vld;
    logic              prio_hit;
    logic              cur_req;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req (bus.Req_In),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

`ifdef DEMUX_SCHED_PRIO_EN
    assign prio_hit = bus.Req_In[0];
`else
    assign prio_hit = 1'b0;
`endif

    assign cur_req            = bus.Req_In[sel_q];
    assign bus.Data_Ready_Out = (state_q == BURST) && cur_req;
    assign bus.Data_Out       = bus.Data_In;
    assign bus.Select_Out     = sel_q;
    assign bus.Enable_Out     = en_q;
    assign bus.Grant_Out      = grant_q;
    assign bus.Busy_Out       = (state_q != IDLE);
    assign bus.Burst_Done_Out = done_q;
    assign bus.Abort_Out      = abort_q;

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            ptr_q   <= SEL_W'(NUM_CH - 1);
            cnt_q   <= '0;
            gap_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            grant_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        en_d    = en_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (prio_hit || arb_vld) begin
                    state_d = BURST;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    if (prio_hit) begin
                        // Priority grants leave the pointer alone so RR fairness among the rest is kept.
                        sel_d   = '0;
                        grant_d = NUM_CH'(1);
                    end else begin
                        sel_d   = arb_idx;
                        grant_d = arb_gnt;
                        ptr_d   = arb_idx;
                    end
                end
            end
            BURST: begin
                if (!cur_req) begin
                    // Consumer withdrew mid-burst: cut it short and flag the abort.
                    state_d = AFTER_BURST;
                    en_d    = 1'b0;
                    grant_d = '0;
                    gap_d   = '0;
                    done_d  = 1'b1;
                    abort_d = 1'b1;
                end else if (bus.Data_Valid_In) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = AFTER_BURST;
                        en_d    = 1'b0;
                        grant_d = '0;
                        gap_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Purpose : directed self-checking bench for demux_burst_scheduler (8 ch, 4-beat bursts, 1 gap cycle).
// Latency : expects grant 1 cycle after IDLE sees a request, done/abort pulse the cycle after the burst.
// Backpressure : drives Valid patterns and request drops to exercise stalls and aborts.
module tb_demux_burst_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_burst_scheduler_if #(.NUM_CH(8), .SEL_W(3)) bus ();

    demux_burst_scheduler #(
        .NUM_CH     (8),
        .SEL_W      (3),
        .BURST_LEN  (4),
        .GAP_CYCLES (1)
    ) dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " enable"}, 32'(bus.Enable_Out), 0);
        check({tag, " grant"},  32'(bus.Grant_Out), 0);
        check({tag, " select"}, 32'(bus.Select_Out), 0);
        check({tag, " busy"},   32'(bus.Busy_Out), 0);
        check({tag, " done"},   32'(bus.Burst_Done_Out), 0);
        check({tag, " abort"},  32'(bus.Abort_Out), 0);
        check({tag, " ready"},  32'(bus.Data_Ready_Out), 0);
    endtask

    // Leaves the bench at a negedge with reset released and the DUT in IDLE.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        bus.Req_In = '0;
        bus.Data_Valid_In = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs(tag);
        rst = 1'b0;
    endtask

    // Follows one burst from grant to the end of its gap; ends on the IDLE cycle that follows.
    task automatic observe_burst(input string tag, input int exp_sel, input int exp_cycles,
                                 input int exp_beats, input bit exp_abort, input bit toggle,
                                 input int drop_after);
        int waited = 0;
        int cycles = 0;
        int beats  = 0;
        logic [7:0] exp_gnt;
        exp_gnt = 8'b1 << exp_sel;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.Enable_Out && waited < 20);
        check({tag, " grant latency"}, 32'(waited), 1);
        check({tag, " select"}, 32'(bus.Select_Out), 32'(exp_sel));
        check({tag, " grant onehot"}, 32'(bus.Grant_Out), 32'(exp_gnt));
        while (bus.Enable_Out && cycles < 40) begin
            cycles++;
            if (bus.Data_Valid_In && bus.Data_Ready_Out) beats++;
            check({tag, " no done mid-burst"}, 32'(bus.Burst_Done_Out), 0);
            @(posedge clk);
            #1;
            if (toggle) bus.Data_Valid_In = ~bus.Data_Valid_In;
            if (drop_after > 0 && beats >= drop_after) bus.Req_In = '0;
            @(negedge clk);
        end
        check({tag, " enable cycles"}, 32'(cycles), 32'(exp_cycles));
        check({tag, " beats"}, 32'(beats), 32'(exp_beats));
        check({tag, " done pulse"}, 32'(bus.Burst_Done_Out), 1);
        check({tag, " abort pulse"}, 32'(bus.Abort_Out), 32'(exp_abort));
        check({tag, " grant cleared"}, 32'(bus.Grant_Out), 0);
        check({tag, " select held"}, 32'(bus.Select_Out), 32'(exp_sel));
        check({tag, " busy in gap"}, 32'(bus.Busy_Out), 1);
        check({tag, " ready low in gap"}, 32'(bus.Data_Ready_Out), 0);
        @(negedge clk);
        check({tag, " idle after gap"}, 32'(bus.Busy_Out), 0);
        check({tag, " done single"}, 32'(bus.Burst_Done_Out), 0);
    endtask

    function automatic int rr_or_prio(input int rr_sel);
`ifdef DEMUX_SCHED_PRIO_EN
        return (rr_sel >= 0) ? 0 : 0;
`else
        return rr_sel;
`endif
    endfunction

    initial begin
        int waited;
        bus.Req_In        = '0;
        bus.Data_Valid_In = 1'b0;
        bus.Data_In       = 1'b0;

        // Reset state
        do_reset("reset");

        // Data path is a straight combinational pass
        bus.Data_In = 1'b1;
        #1 check("data pass 1", 32'(bus.Data_Out), 1);
        bus.Data_In = 1'b0;
        #1 check("data pass 0", 32'(bus.Data_Out), 0);

        // 1: ch0 and ch7 alternate from the reset pointer (ch0 only with priority)
        do_reset("t1 reset");
        bus.Req_In = 8'b1000_0001;
        bus.Data_Valid_In = 1'b1;
        observe_burst("t1 b0", rr_or_prio(0), 4, 4, 1'b0, 1'b0, 0);
        observe_burst("t1 b1", rr_or_prio(7), 4, 4, 1'b0, 1'b0, 0);
        observe_burst("t1 b2", rr_or_prio(0), 4, 4, 1'b0, 1'b0, 0);

        // 2: single channel, full burst
        do_reset("t2 reset");
        bus.Req_In = 8'h04;
        bus.Data_Valid_In = 1'b1;
        observe_burst("t2", 2, 4, 4, 1'b0, 1'b0, 0);

        // 3: all channels requesting -> 0..7 then wrap to 0
        do_reset("t3 reset");
        bus.Req_In = 8'hFF;
        bus.Data_Valid_In = 1'b1;
        for (int i = 0; i < 9; i++) begin
            observe_burst($sformatf("t3 b%0d", i), rr_or_prio(i % 8), 4, 4, 1'b0, 1'b0, 0);
        end

        // 4: Valid alternates starting low in the first burst cycle -> 8 cycles for 4 beats
        do_reset("t4 reset");
        bus.Req_In = 8'h10;
        bus.Data_Valid_In = 1'b0;
        observe_burst("t4", 4, 8, 4, 1'b0, 1'b1, 0);

        // 5: request dropped after two beats -> aborted burst
        do_reset("t5 reset");
        bus.Req_In = 8'h02;
        bus.Data_Valid_In = 1'b1;
        observe_burst("t5", 1, 3, 2, 1'b1, 1'b0, 2);

        // 6: reset mid-burst clears everything without a done pulse
        do_reset("t6 reset");
        bus.Req_In = 8'h08;
        bus.Data_Valid_In = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.Enable_Out && waited < 20);
        check("t6 burst started", 32'(bus.Enable_Out), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6 mid reset");
        @(negedge clk);
        check("t6 no late done", 32'(bus.Burst_Done_Out), 0);
        rst = 1'b0;
        observe_burst("t6 regrant", 3, 4, 4, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
